// File: rtl/puf_eval_sequencer.sv
// Arbiter-PUF evaluation sequencer: per-bit challenge setup,
// repeated race pulses, synchronised sampling and majority voting.
module puf_eval_sequencer #(
    parameter int C_LENGTH   = 8,
    parameter int N_BITS     = 8,
    parameter int REPEAT     = 3,
    parameter int SETTLE_CYC = 4,
    parameter int PULSE_CYC  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [C_LENGTH-1:0] i_seed,
    output logic                o_busy,
    output logic                o_pulse,
    output logic [C_LENGTH-1:0] o_challenge,
    input  logic                i_response,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [N_BITS-1:0]   o_response,
    output logic                o_unstable
);

    localparam int CNT_MAX = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int REP_W   = $clog2(REPEAT + 1);
    localparam int K_W     = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE_HI,
        S_PULSE_LO,
        S_SAMPLE,
        S_VOTE,
        S_OUTPUT
    } state_t;

    state_t              state_q;
    logic [C_LENGTH-1:0] seed_q;
    logic [K_W-1:0]      k_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [REP_W-1:0]    rep_q;
    logic [REP_W-1:0]    ones_q;
    logic [N_BITS-1:0]   word_q;
    logic                unst_q;
    logic                load_q;
    logic                sync1_q;
    logic                sync2_q;

    logic [REP_W-1:0]    rep_d;
    logic [REP_W-1:0]    ones_d;
    logic [K_W-1:0]      k_d;
    logic                vote_d;
    logic                mixed_d;
    logic [N_BITS-1:0]   word_d;

    // Vote arithmetic and next-bit index for the current evaluation.
    always_comb begin
        rep_d         = rep_q + REP_W'(1);
        ones_d        = ones_q + REP_W'(sync2_q);
        k_d           = k_q + K_W'(1);
        vote_d        = ones_q > REP_W'(REPEAT / 2);
        mixed_d       = (ones_q != '0) && (ones_q != REP_W'(REPEAT));
        word_d        = word_q;
        word_d[k_q]   = vote_d;
    end

    // Sequencer FSM with registered outputs and response synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            rep_q       <= '0;
            ones_q      <= '0;
            word_q      <= '0;
            unst_q      <= 1'b0;
            load_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            o_busy      <= 1'b0;
            o_pulse     <= 1'b0;
            o_challenge <= '0;
            o_valid     <= 1'b0;
            o_response  <= '0;
            o_unstable  <= 1'b0;
        end else begin
            sync1_q <= i_response;
            sync2_q <= sync1_q;
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        seed_q  <= i_seed;
                        k_q     <= '0;
                        cnt_q   <= '0;
                        rep_q   <= '0;
                        ones_q  <= '0;
                        word_q  <= '0;
                        unst_q  <= 1'b0;
                        load_q  <= 1'b1;
                        o_busy  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // First bit: the captured seed reaches the pins one
                    // cycle late, so settling starts after that load.
                    if (load_q) begin
                        o_challenge <= seed_q;
                        load_q      <= 1'b0;
                    end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        cnt_q   <= '0;
                        o_pulse <= 1'b1;
                        state_q <= S_PULSE_HI;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PULSE_HI: begin
                    if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
                        cnt_q   <= '0;
                        o_pulse <= 1'b0;
                        state_q <= S_PULSE_LO;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PULSE_LO: begin
                    if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    ones_q <= ones_d;
                    rep_q  <= rep_d;
                    if (rep_d < REP_W'(REPEAT)) begin
                        o_pulse <= 1'b1;
                        state_q <= S_PULSE_HI;
                    end else begin
                        state_q <= S_VOTE;
                    end
                end
                S_VOTE: begin
                    word_q <= word_d;
                    unst_q <= unst_q | mixed_d;
                    ones_q <= '0;
                    rep_q  <= '0;
                    if (k_q == K_W'(N_BITS - 1)) begin
                        o_response <= word_d;
                        o_unstable <= unst_q | mixed_d;
                        o_valid    <= 1'b1;
                        state_q    <= S_OUTPUT;
                    end else begin
                        k_q         <= k_d;
                        o_challenge <= seed_q + C_LENGTH'(k_d);
                        cnt_q       <= '0;
                        state_q     <= S_SETUP;
                    end
                end
                S_OUTPUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Self-checking bench for puf_eval_sequencer with a behavioural
// PUF model and a word-level reference of the voting rules.
module tb_puf_eval_sequencer;

    localparam int NB  = 8;
    localparam int REP = 3;
    localparam int SET = 4;
    localparam int PUL = 2;
    localparam int LAT = 1 + NB * (SET + REP * (PUL + SET + 1) + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_seed = 8'h00;
    logic       o_busy;
    logic       o_pulse;
    logic [7:0] o_challenge;
    logic       i_response = 1'b0;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic [7:0] o_response;
    logic       o_unstable;

    int vectors = 0;
    int errors  = 0;

    // PUF model state
    int         mode = 0;
    int         run_no = 0;
    int         model_run = -1;
    int         pulses_run = 0;
    int         ones_seen [NB];
    logic [7:0] ch_seen [NB];
    int         pb;
    int         pe;
    logic       pr;

    // pulse-gap monitor state
    int   low_run = 0;
    int   min_gap = 1000;
    logic prev_pulse = 1'b0;

    puf_eval_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_seed      (i_seed),
        .o_busy      (o_busy),
        .o_pulse     (o_pulse),
        .o_challenge (o_challenge),
        .i_response  (i_response),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_response  (o_response),
        .o_unstable  (o_unstable)
    );

    always #5 clk = ~clk;

    // PUF: each rising pulse produces a fresh one-bit race outcome.
    always @(posedge o_pulse) begin
        if (model_run != run_no) begin
            model_run  = run_no;
            pulses_run = 0;
            for (int i = 0; i < NB; i++) begin
                ones_seen[i] = 0;
                ch_seen[i]   = 8'h00;
            end
        end
        pb = pulses_run / REP;
        pe = pulses_run % REP + 1;
        case (mode)
            0:       pr = ^o_challenge;
            1:       pr = (pb == 2) && (pe == 1 || pe == 3);
            default: pr = 1'($urandom_range(0, 1));
        endcase
        if (pb < NB) begin
            ch_seen[pb] = o_challenge;
            if (pr) ones_seen[pb]++;
        end
        i_response = pr;
        pulses_run++;
    end

    // Shortest low stretch preceding any o_pulse rise.
    always @(posedge clk) begin
        if (o_pulse === 1'b1) begin
            if (prev_pulse !== 1'b1 && low_run < min_gap) min_gap = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_pulse = o_pulse;
    end

    // Reference: word and unstable flag from the voting rules.
    function automatic logic [8:0] expected(input logic [7:0] seed, input int m);
        logic [7:0] w;
        logic       u;
        logic [7:0] ch;
        w = 8'h00;
        u = 1'b0;
        for (int b = 0; b < NB; b++) begin
            ch = seed + 8'(b);
            case (m)
                0: w[b] = ^ch;
                1: begin
                    w[b] = (b == 2);
                    u    = u | (b == 2);
                end
                default: begin
                    w[b] = ones_seen[b] > REP / 2;
                    u    = u | (ones_seen[b] != 0 && ones_seen[b] != REP);
                end
            endcase
        end
        return {u, w};
    endfunction

    task automatic launch(input logic [7:0] seed);
        run_no++;
        i_seed  = seed;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic await_valid(output int lat);
        lat = 0;
        while (o_valid !== 1'b1 && lat < LAT + 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        i_start = 1'b1;
        i_seed  = 8'hA5;
        repeat (3) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({o_busy, o_pulse, o_valid, o_unstable} !== 4'b0000 ||
                o_challenge !== 8'h00 || o_response !== 8'h00) begin
                errors++;
                $display("FAIL reset: busy=%b pulse=%b valid=%b unst=%b ch=%h resp=%h want all 0",
                         o_busy, o_pulse, o_valid, o_unstable, o_challenge, o_response);
            end
        end
        i_start = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (o_busy !== 1'b0 || o_pulse !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b pulse=%b want 0 0", o_busy, o_pulse);
        end
    endtask

    task automatic test_functional;
        int         lat;
        logic [8:0] e;
        mode = 0;
        launch(8'h00);
        vectors++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_on_start: got %b want 1", o_busy);
        end
        await_valid(lat);
        e = expected(8'h00, 0);
        vectors++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", lat, LAT);
        end
        vectors++;
        if (o_response !== e[7:0] || o_unstable !== e[8]) begin
            errors++;
            $display("FAIL word_seed00: got %h/%b want %h/%b", o_response, o_unstable, e[7:0], e[8]);
        end
        vectors++;
        if (pulses_run != NB * REP) begin
            errors++;
            $display("FAIL pulse_count: got %0d want %0d", pulses_run, NB * REP);
        end
        for (int b = 0; b < NB; b++) begin
            vectors++;
            if (ch_seen[b] !== 8'(b)) begin
                errors++;
                $display("FAIL challenge_%0d: got %h want %h", b, ch_seen[b], 8'(b));
            end
        end
        handshake();
        vectors++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL handoff: valid=%b busy=%b want 0 0", o_valid, o_busy);
        end
    endtask

    task automatic test_wrap;
        int         lat;
        logic [8:0] e;
        logic [7:0] s;
        s    = 8'hFC;
        mode = 0;
        launch(s);
        await_valid(lat);
        e = expected(s, 0);
        vectors++;
        if (lat != LAT || o_response !== e[7:0] || o_unstable !== e[8]) begin
            errors++;
            $display("FAIL wrap_word: lat=%0d word=%h/%b want %0d %h/%b",
                     lat, o_response, o_unstable, LAT, e[7:0], e[8]);
        end
        for (int b = 0; b < NB; b++) begin
            vectors++;
            if (ch_seen[b] !== s + 8'(b)) begin
                errors++;
                $display("FAIL wrap_ch_%0d: got %h want %h", b, ch_seen[b], s + 8'(b));
            end
        end
        for (int c = 0; c < 10; c++) begin
            i_start = (c == 3 || c == 4);
            i_seed  = 8'h55;
            @(posedge clk);
            #1;
            vectors++;
            if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_response !== e[7:0]) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b busy=%b word=%h want 1 1 %h",
                         c, o_valid, o_busy, o_response, e[7:0]);
            end
        end
        i_start = 1'b0;
        handshake();
        @(posedge clk);
        #1;
        vectors++;
        if (o_busy !== 1'b0 || o_pulse !== 1'b0) begin
            errors++;
            $display("FAIL start_not_queued: busy=%b pulse=%b want 0 0", o_busy, o_pulse);
        end
    endtask

    task automatic test_majority;
        int         lat;
        logic [8:0] e;
        mode = 1;
        launch(8'h00);
        await_valid(lat);
        e = expected(8'h00, 1);
        vectors++;
        if (o_response !== e[7:0] || o_unstable !== e[8]) begin
            errors++;
            $display("FAIL majority: got %h/%b want %h/%b", o_response, o_unstable, e[7:0], e[8]);
        end
        handshake();
    endtask

    task automatic test_random;
        int         lat;
        int         dly;
        logic [7:0] s;
        logic [8:0] e;
        mode = 2;
        for (int r = 0; r < 4; r++) begin
            s   = 8'($urandom);
            dly = $urandom_range(0, 5);
            launch(s);
            await_valid(lat);
            e = expected(s, 2);
            vectors++;
            if (lat != LAT || o_response !== e[7:0] || o_unstable !== e[8]) begin
                errors++;
                $display("FAIL random_%0d seed=%h: lat=%0d word=%h/%b want %0d %h/%b",
                         r, s, lat, o_response, o_unstable, LAT, e[7:0], e[8]);
            end
            repeat (dly) begin
                @(posedge clk);
                #1;
                vectors++;
                if (o_valid !== 1'b1 || o_response !== e[7:0]) begin
                    errors++;
                    $display("FAIL random_hold_%0d: valid=%b word=%h want 1 %h",
                             r, o_valid, o_response, e[7:0]);
                end
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back;
        int         lat;
        logic [8:0] e;
        logic [7:0] s2;
        mode = 0;
        s2   = 8'h3A;
        launch(8'h81);
        await_valid(lat);
        e = expected(8'h81, 0);
        vectors++;
        if (o_response !== e[7:0]) begin
            errors++;
            $display("FAIL b2b_first: got %h want %h", o_response, e[7:0]);
        end
        run_no++;
        i_seed  = s2;
        i_start = 1'b1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        vectors++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b valid=%b want 0 0", o_busy, o_valid);
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
        vectors++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b want 1", o_busy);
        end
        await_valid(lat);
        e = expected(s2, 0);
        vectors++;
        if (lat != LAT || o_response !== e[7:0] || o_unstable !== e[8]) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d word=%h/%b want %0d %h/%b",
                     lat, o_response, o_unstable, LAT, e[7:0], e[8]);
        end
        handshake();
    endtask

    task automatic test_midreset;
        int         lat;
        int         w;
        logic [8:0] e;
        mode = 0;
        launch(8'h10);
        w = 0;
        while (!(o_pulse === 1'b1 && o_challenge === 8'h14) && w < LAT) begin
            @(posedge clk);
            #1;
            w++;
        end
        vectors++;
        if (w >= LAT) begin
            errors++;
            $display("FAIL midreset_wait: bit-4 pulse not seen in %0d cycles", w);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (o_pulse !== 1'b0 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset: pulse=%b busy=%b valid=%b want 0 0 0",
                     o_pulse, o_busy, o_valid);
        end
        launch(8'hC7);
        await_valid(lat);
        e = expected(8'hC7, 0);
        vectors++;
        if (lat != LAT || o_response !== e[7:0] || o_unstable !== e[8]) begin
            errors++;
            $display("FAIL after_reset_word: lat=%0d word=%h/%b want %0d %h/%b",
                     lat, o_response, o_unstable, LAT, e[7:0], e[8]);
        end
        handshake();
    endtask

    task automatic test_pulse_gap;
        vectors++;
        if (min_gap < SET) begin
            errors++;
            $display("FAIL pulse_gap: shortest low run %0d want >= %0d", min_gap, SET);
        end
    endtask

    initial begin
        test_reset();
        test_functional();
        test_wrap();
        test_majority();
        test_random();
        test_back_to_back();
        test_midreset();
        test_pulse_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
